// File: rtl/sync_segment_generator_pkg.sv
// Shared segment encoding and reference 640x480 timing for the sync segment generators.
// Timing constants feed the lengths of the horizontal and vertical instances at system level.
package sync_segment_generator_pkg;

    localparam logic [1:0] SEG_SYNC   = 2'd0;
    localparam logic [1:0] SEG_BACK   = 2'd1;
    localparam logic [1:0] SEG_ACTIVE = 2'd2;
    localparam logic [1:0] SEG_FRONT  = 2'd3;

    typedef enum logic [1:0] {
        SegSync   = SEG_SYNC,
        SegBack   = SEG_BACK,
        SegActive = SEG_ACTIVE,
        SegFront  = SEG_FRONT
    } seg_e;

    localparam int unsigned H_SYNC_LEN   = 96;
    localparam int unsigned H_BACK_LEN   = 48;
    localparam int unsigned H_ACTIVE_LEN = 640;
    localparam int unsigned H_FRONT_LEN  = 16;

    localparam int unsigned V_SYNC_LEN   = 2;
    localparam int unsigned V_BACK_LEN   = 33;
    localparam int unsigned V_ACTIVE_LEN = 480;
    localparam int unsigned V_FRONT_LEN  = 10;

    function automatic seg_e next_seg(input seg_e cur);
        seg_e nxt;
        unique case (cur)
            SegSync:   nxt = SegBack;
            SegBack:   nxt = SegActive;
            SegActive: nxt = SegFront;
            SegFront:  nxt = SegSync;
            default:   nxt = SegSync;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync_segment_generator_advance_qualifier.sv
// Turns the raw advance input into a one-clock count enable, either as a level or as
// a rising-edge detect.
module sync_segment_generator_advance_qualifier #(
    parameter bit ADVANCE_EDGE = 1'b0
) (
    input  logic clock,
    input  logic advance_i,
    output logic qadv_o
);

    logic adv_q;

    // Tracks advance unconditionally, so a level held high across reset release is not an edge.
    always_ff @(posedge clock) begin
        adv_q <= advance_i;
    end

    assign qadv_o = ADVANCE_EDGE ? (advance_i & ~adv_q) : advance_i;

endmodule

// File: rtl/sync_segment_generator.sv
// Generic sync/position generator: SYNC, BACK, ACTIVE, FRONT segments with shadowed lengths
// and registered outputs. Used once per display axis.
module sync_segment_generator
    import sync_segment_generator_pkg::*;
#(
    parameter int unsigned WIDTH            = 10,
    parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
    parameter bit          ADVANCE_EDGE     = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] sync_len,
    input  logic [WIDTH-1:0] back_len,
    input  logic [WIDTH-1:0] active_len,
    input  logic [WIDTH-1:0] front_len,
    output logic             sync,
    output logic             active,
    output logic [WIDTH-1:0] position,
    output logic [1:0]       segment,
    output logic             period_end
);

    logic qadv;

    seg_e             state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sync_sh_q, sync_sh_d;
    logic [WIDTH-1:0] back_sh_q, back_sh_d;
    logic [WIDTH-1:0] active_sh_q, active_sh_d;
    logic [WIDTH-1:0] front_sh_q, front_sh_d;

    logic             sync_q, sync_d;
    logic             active_q, active_d;
    logic [WIDTH-1:0] position_q, position_d;
    logic [1:0]       segment_q, segment_d;
    logic             period_end_q, period_end_d;

    logic [WIDTH-1:0] len_sel;
    logic [WIDTH-1:0] len_eff;
    logic             at_last;
    logic             wrap;

    sync_segment_generator_advance_qualifier #(
        .ADVANCE_EDGE(ADVANCE_EDGE)
    ) u_adv_qual (
        .clock    (clock),
        .advance_i(advance),
        .qadv_o   (qadv)
    );

    always_comb begin
        len_sel = sync_sh_q;
        unique case (state_q)
            SegSync:   len_sel = sync_sh_q;
            SegBack:   len_sel = back_sh_q;
            SegActive: len_sel = active_sh_q;
            SegFront:  len_sel = front_sh_q;
            default:   len_sel = sync_sh_q;
        endcase
        // A zero length still occupies one count, so no segment is ever skipped.
        len_eff = (len_sel == '0) ? WIDTH'(1) : len_sel;
        at_last = (cnt_q == (len_eff - WIDTH'(1)));

        state_d = state_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (qadv) begin
            if (at_last) begin
                state_d = next_seg(state_q);
                cnt_d   = '0;
                wrap    = (state_q == SegFront);
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end

        sync_sh_d   = wrap ? sync_len   : sync_sh_q;
        back_sh_d   = wrap ? back_len   : back_sh_q;
        active_sh_d = wrap ? active_len : active_sh_q;
        front_sh_d  = wrap ? front_len  : front_sh_q;

        sync_d       = ((state_d == SegSync) == SYNC_ACTIVE_HIGH);
        active_d     = (state_d == SegActive);
        position_d   = active_d ? cnt_d : '0;
        segment_d    = state_d;
        period_end_d = wrap;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= SegSync;
            cnt_q        <= '0;
            sync_sh_q    <= sync_len;
            back_sh_q    <= back_len;
            active_sh_q  <= active_len;
            front_sh_q   <= front_len;
            sync_q       <= SYNC_ACTIVE_HIGH;
            active_q     <= 1'b0;
            position_q   <= '0;
            segment_q    <= SEG_SYNC;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync_sh_q    <= sync_sh_d;
            back_sh_q    <= back_sh_d;
            active_sh_q  <= active_sh_d;
            front_sh_q   <= front_sh_d;
            sync_q       <= sync_d;
            active_q     <= active_d;
            position_q   <= position_d;
            segment_q    <= segment_d;
            period_end_q <= period_end_d;
        end
    end

    assign sync       = sync_q;
    assign active     = active_q;
    assign position   = position_q;
    assign segment    = segment_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_sync_segment_generator.sv
// Bench: level-mode active-low instance and edge-mode active-high instance, driven with
// directed vector tables and a few hand-written multi-cycle sequences.
module tb_sync_segment_generator;

    localparam int unsigned W = 10;

    logic clock;

    logic         l_reset, l_adv;
    logic [W-1:0] l_sync_len, l_back_len, l_act_len, l_front_len;
    logic         l_sync, l_active, l_pe;
    logic [W-1:0] l_pos;
    logic [1:0]   l_seg;

    logic         e_reset, e_adv;
    logic [W-1:0] e_sync_len, e_back_len, e_act_len, e_front_len;
    logic         e_sync, e_active, e_pe;
    logic [W-1:0] e_pos;
    logic [1:0]   e_seg;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic         rst;
        logic         adv;
        logic [1:0]   seg;
        logic         sync;
        logic         act;
        logic [W-1:0] pos;
        logic         pe;
    } vec_t;

    vec_t vecs[$];

    sync_segment_generator #(
        .WIDTH(W), .SYNC_ACTIVE_HIGH(1'b0), .ADVANCE_EDGE(1'b0)
    ) dut_lvl (
        .clock(clock), .reset(l_reset), .advance(l_adv),
        .sync_len(l_sync_len), .back_len(l_back_len), .active_len(l_act_len),
        .front_len(l_front_len), .sync(l_sync), .active(l_active), .position(l_pos),
        .segment(l_seg), .period_end(l_pe)
    );

    sync_segment_generator #(
        .WIDTH(W), .SYNC_ACTIVE_HIGH(1'b1), .ADVANCE_EDGE(1'b1)
    ) dut_edge (
        .clock(clock), .reset(e_reset), .advance(e_adv),
        .sync_len(e_sync_len), .back_len(e_back_len), .active_len(e_act_len),
        .front_len(e_front_len), .sync(e_sync), .active(e_active), .position(e_pos),
        .segment(e_seg), .period_end(e_pe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic apply_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            l_reset = vecs[i].rst;
            l_adv   = vecs[i].adv;
            tick();
            check($sformatf("%s[%0d] segment", tag, i), 32'(l_seg), 32'(vecs[i].seg));
            check($sformatf("%s[%0d] sync", tag, i), 32'(l_sync), 32'(vecs[i].sync));
            check($sformatf("%s[%0d] active", tag, i), 32'(l_active), 32'(vecs[i].act));
            check($sformatf("%s[%0d] position", tag, i), 32'(l_pos), 32'(vecs[i].pos));
            check($sformatf("%s[%0d] period_end", tag, i), 32'(l_pe), 32'(vecs[i].pe));
        end
        l_reset = 1'b0;
    endtask

    // Reset vector followed by n_ticks counting steps read from a per-index table.
    task automatic build_vecs(input int n_ticks, input int period,
                              input int seg_tab[16], input int pos_tab[16]);
        vec_t v;
        vecs.delete();
        v.rst = 1'b1; v.adv = 1'b1; v.seg = 2'd0; v.sync = 1'b0;
        v.act = 1'b0; v.pos = '0; v.pe = 1'b0;
        vecs.push_back(v);
        for (int n = 1; n <= n_ticks; n++) begin
            int idx;
            idx   = n % period;
            v.rst = 1'b0;
            v.adv = 1'b1;
            v.seg = 2'(seg_tab[idx]);
            v.sync = (seg_tab[idx] != 0);
            v.act = (seg_tab[idx] == 2);
            v.pos = W'(pos_tab[idx]);
            v.pe  = (idx == 0);
            vecs.push_back(v);
        end
    endtask

    task automatic lvl_reset();
        l_reset = 1'b1;
        l_adv   = 1'b1;
        tick();
        l_reset = 1'b0;
    endtask

    initial begin
        int seg_a[16] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 0, 0, 0, 0};
        int pos_a[16] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
        int seg_b[16] = '{0, 0, 1, 2, 2, 2, 2, 2, 3, 3, 0, 0, 0, 0, 0, 0};
        int pos_b[16] = '{0, 0, 0, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        int act1, act2, pe_cnt, first_pe, second_pe;
        logic frozen;

        l_reset = 1'b1; l_adv = 1'b1;
        l_sync_len = 10'd2; l_back_len = 10'd3; l_act_len = 10'd5; l_front_len = 10'd2;
        e_reset = 1'b1; e_adv = 1'b0;
        e_sync_len = 10'd2; e_back_len = 10'd3; e_act_len = 10'd5; e_front_len = 10'd2;

        // Level mode, 2/3/5/2: 12-clock period, two periods.
        build_vecs(24, 12, seg_a, pos_a);
        apply_vecs("lvl_2352");

        // Zero back porch behaves as one count: 10-count period.
        l_back_len = 10'd0;
        build_vecs(20, 10, seg_b, pos_b);
        apply_vecs("lvl_back0");
        l_back_len = 10'd3;

        // Mid-period active_len change only applies to the following period.
        lvl_reset();
        act1 = 0; act2 = 0;
        for (int t = 1; t <= 26; t++) begin
            if (t == 7) l_act_len = 10'd7;
            tick();
            if (t <= 12) act1 += int'(l_active);
            else act2 += int'(l_active);
            if (t == 12) check("shadow old period_end", 32'(l_pe), 32'd1);
            if (t == 23) check("shadow new last position", 32'(l_pos), 32'd6);
            if (t == 24) check("shadow no early period_end", 32'(l_pe), 32'd0);
            if (t == 26) check("shadow new period_end", 32'(l_pe), 32'd1);
        end
        check("shadow old active count", 32'(act1), 32'd5);
        check("shadow new active count", 32'(act2), 32'd7);
        l_act_len = 10'd5;

        // Reset pulse in ACTIVE at position 3; shadows reload with the new active_len.
        lvl_reset();
        for (int t = 1; t <= 8; t++) tick();
        check("midrst pre position", 32'(l_pos), 32'd3);
        check("midrst pre segment", 32'(l_seg), 32'd2);
        l_act_len = 10'd3;
        l_reset = 1'b1;
        tick();
        l_reset = 1'b0;
        check("midrst segment", 32'(l_seg), 32'd0);
        check("midrst sync", 32'(l_sync), 32'd0);
        check("midrst active", 32'(l_active), 32'd0);
        check("midrst position", 32'(l_pos), 32'd0);
        check("midrst period_end", 32'(l_pe), 32'd0);
        act1 = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            act1 += int'(l_active);
            if (t == 1) check("midrst restart seg t1", 32'(l_seg), 32'd0);
            if (t == 2) check("midrst restart seg t2", 32'(l_seg), 32'd1);
            if (t == 10) check("midrst period_end", 32'(l_pe), 32'd1);
        end
        check("midrst reloaded active count", 32'(act1), 32'd3);
        l_act_len = 10'd5;

        // Advance low for 50 clocks mid-ACTIVE freezes everything.
        lvl_reset();
        for (int t = 1; t <= 7; t++) tick();
        l_adv = 1'b0;
        frozen = 1'b1;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (l_seg != 2'd2 || l_pos != 10'd2 || !l_active || l_pe || !l_sync) frozen = 1'b0;
        end
        check("hold frozen", 32'(frozen), 32'd1);
        l_adv = 1'b1;
        tick();
        check("hold resume position", 32'(l_pos), 32'd3);
        check("hold resume segment", 32'(l_seg), 32'd2);

        // Edge mode: reset for edges 0..11, advance toggles every 6 clocks.
        act1 = 0; pe_cnt = 0; first_pe = -1; second_pe = -1;
        for (int c = 0; c < 300; c++) begin
            e_reset = (c < 12);
            e_adv   = ((c / 6) % 2) == 1;
            tick();
            if (c == 0) check("edge reset sync", 32'(e_sync), 32'd1);
            if (c == 12) check("edge release segment", 32'(e_seg), 32'd0);
            if (c >= 12 && c < 150) act1 += int'(e_active);
            if (c >= 12 && e_pe) begin
                pe_cnt++;
                if (first_pe < 0) first_pe = c;
                else if (second_pe < 0) second_pe = c;
            end
        end
        check("edge first period_end", 32'(first_pe), 32'd150);
        check("edge second period_end", 32'(second_pe), 32'd294);
        check("edge period_end count", 32'(pe_cnt), 32'd2);
        check("edge active clocks", 32'(act1), 32'd60);

        // Edge mode: advance high across reset release must not count.
        e_sync_len = 10'd1;
        e_reset = 1'b1; e_adv = 1'b1;
        tick();
        tick();
        e_reset = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        check("edge no count at release", 32'(e_seg), 32'd0);
        check("edge sync held", 32'(e_sync), 32'd1);
        e_adv = 1'b0;
        tick();
        check("edge falling no count", 32'(e_seg), 32'd0);
        e_adv = 1'b1;
        tick();
        check("edge rising counts", 32'(e_seg), 32'd1);
        check("edge sync deasserted", 32'(e_sync), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
